// File: rtl/ir_nec_rx.sv
// rtl/ir_nec_rx.sv - NEC infrared frame receiver with windowed timing, repeat detection and error codes
module ir_nec_rx #(
    parameter int          IR_ACTIVE_LOW = 1,
    parameter int          SYNC_STAGES   = 2,
    parameter int unsigned TOL_US        = 200,
    parameter int unsigned LEAD_MARK_US  = 9000,
    parameter int unsigned LEAD_SPACE_US = 4500,
    parameter int unsigned REP_SPACE_US  = 2250,
    parameter int unsigned BIT_MARK_US   = 560,
    parameter int unsigned BIT0_SPACE_US = 560,
    parameter int unsigned BIT1_SPACE_US = 1690,
    parameter int unsigned TIMEOUT_US    = 12000,
    parameter int unsigned REPEAT_WIN_US = 110000,
    parameter int          CHECK_ADDR    = 0,
    parameter int          CHECK_CMD     = 1
) (
    input  logic        clk_1m,
    input  logic        rst_n,
    input  logic        ir,
    output logic [31:0] frame,
    output logic [15:0] addr,
    output logic [7:0]  cmd,
    output logic        valid,
    output logic        repeat_pulse,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_M, S_LEAD_S, S_BIT_M, S_BIT_S, S_STOP_M, S_REP_M
    } state_t;

    localparam logic       IDLE_LVL     = (IR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [2:0] E_BAD_LEAD   = 3'd1;
    localparam logic [2:0] E_BAD_SPACE  = 3'd2;
    localparam logic [2:0] E_BAD_BIT    = 3'd3;
    localparam logic [2:0] E_CHECK_FAIL = 3'd4;
    localparam logic [2:0] E_TIMEOUT    = 3'd5;
    localparam logic [2:0] E_ORPHAN_REP = 3'd6;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_m_d;
    logic                   r_mark_start;
    logic                   r_mark_end;
    logic [15:0]            r_seg_cnt;
    logic [4:0]             r_bit_cnt;
    logic [31:0]            r_shift;
    logic [16:0]            r_rep_cnt;
    logic                   r_rep_open;

    logic w_m;
    logic w_timeout;
    logic w_checks_ok;
    logic w_bit0;
    logic w_bit1;

    function automatic logic f_in(input logic [15:0] d, input int unsigned n);
        int unsigned lo;
        lo = (n > TOL_US) ? (n - TOL_US) : 32'd0;
        return ({16'd0, d} >= lo) && ({16'd0, d} <= (n + TOL_US));
    endfunction

    assign w_m         = r_sync[SYNC_STAGES-1] ^ IDLE_LVL;
    assign w_timeout   = (r_state != S_IDLE) && ({16'd0, r_seg_cnt} > TIMEOUT_US);
    assign w_checks_ok = ((CHECK_ADDR == 0) || (r_shift[15:8] == ~r_shift[7:0])) &&
                         ((CHECK_CMD == 0)  || (r_shift[31:24] == ~r_shift[23:16]));
    assign w_bit0      = f_in(r_seg_cnt, BIT0_SPACE_US);
    assign w_bit1      = f_in(r_seg_cnt, BIT1_SPACE_US);
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk_1m) begin
        if (!rst_n) begin
            r_sync       <= {SYNC_STAGES{IDLE_LVL}};
            r_m_d        <= 1'b0;
            r_mark_start <= 1'b0;
            r_mark_end   <= 1'b0;
            r_seg_cnt    <= 16'd0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], ir};
            r_m_d        <= w_m;
            r_mark_start <= w_m & ~r_m_d;
            r_mark_end   <= ~w_m & r_m_d;
            // Loaded with 1 so the value seen at the next strobe equals the segment length
            if (r_mark_start || r_mark_end)
                r_seg_cnt <= 16'd1;
            else if (r_seg_cnt != 16'hFFFF)
                r_seg_cnt <= r_seg_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_1m) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 5'd0;
            r_shift      <= 32'd0;
            r_rep_cnt    <= 17'd0;
            r_rep_open   <= 1'b0;
            frame        <= 32'd0;
            addr         <= 16'd0;
            cmd          <= 8'd0;
            valid        <= 1'b0;
            repeat_pulse <= 1'b0;
            err          <= 1'b0;
            err_code     <= 3'd0;
        end else begin
            valid        <= 1'b0;
            repeat_pulse <= 1'b0;
            err          <= 1'b0;
            if (r_rep_open) begin
                if (r_rep_cnt != 17'h1FFFF)
                    r_rep_cnt <= r_rep_cnt + 17'd1;
                if ({15'd0, r_rep_cnt} >= REPEAT_WIN_US)
                    r_rep_open <= 1'b0;
            end
            if (w_timeout) begin
                err      <= 1'b1;
                err_code <= E_TIMEOUT;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (r_mark_start) r_state <= S_LEAD_M;
                    S_LEAD_M: if (r_mark_end) begin
                        if (f_in(r_seg_cnt, LEAD_MARK_US)) begin
                            r_state <= S_LEAD_S;
                        end else begin
                            err <= 1'b1; err_code <= E_BAD_LEAD; r_state <= S_IDLE;
                        end
                    end
                    S_LEAD_S: if (r_mark_start) begin
                        if (f_in(r_seg_cnt, LEAD_SPACE_US)) begin
                            r_bit_cnt <= 5'd0;
                            r_state   <= S_BIT_M;
                        end else if (f_in(r_seg_cnt, REP_SPACE_US)) begin
                            r_state <= S_REP_M;
                        end else begin
                            err <= 1'b1; err_code <= E_BAD_SPACE; r_state <= S_IDLE;
                        end
                    end
                    S_BIT_M: if (r_mark_end) begin
                        if (f_in(r_seg_cnt, BIT_MARK_US)) begin
                            r_state <= S_BIT_S;
                        end else begin
                            err <= 1'b1; err_code <= E_BAD_BIT; r_state <= S_IDLE;
                        end
                    end
                    S_BIT_S: if (r_mark_start) begin
                        if (w_bit0 || w_bit1) begin
                            r_shift <= {w_bit1, r_shift[31:1]};
                            if (r_bit_cnt == 5'd31) begin
                                r_state <= S_STOP_M;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                                r_state   <= S_BIT_M;
                            end
                        end else begin
                            err <= 1'b1; err_code <= E_BAD_BIT; r_state <= S_IDLE;
                        end
                    end
                    S_STOP_M: if (r_mark_end) begin
                        r_state <= S_IDLE;
                        if (!f_in(r_seg_cnt, BIT_MARK_US)) begin
                            err <= 1'b1; err_code <= E_BAD_BIT;
                        end else if (!w_checks_ok) begin
                            err <= 1'b1; err_code <= E_CHECK_FAIL;
                        end else begin
                            frame      <= r_shift;
                            addr       <= r_shift[15:0];
                            cmd        <= r_shift[23:16];
                            valid      <= 1'b1;
                            r_rep_cnt  <= 17'd0;
                            r_rep_open <= 1'b1;
                        end
                    end
                    S_REP_M: if (r_mark_end) begin
                        r_state <= S_IDLE;
                        if (!f_in(r_seg_cnt, BIT_MARK_US)) begin
                            err <= 1'b1; err_code <= E_BAD_BIT;
                        end else if (r_rep_open) begin
                            repeat_pulse <= 1'b1;
                            r_rep_cnt    <= 17'd0;
                            r_rep_open   <= 1'b1;
                        end else begin
                            err <= 1'b1; err_code <= E_ORPHAN_REP;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb/tb_ir_nec_rx.sv - self-checking bench for ir_nec_rx with time-scaled NEC timing
module tb_ir_nec_rx;

    localparam int S   = 2;
    localparam int TOL = 10;
    localparam int LM  = 450;
    localparam int LS  = 225;
    localparam int RS  = 112;
    localparam int BM  = 28;
    localparam int B0  = 28;
    localparam int B1  = 84;
    localparam int TO  = 600;
    localparam int RW  = 5500;

    logic        clk_1m = 1'b0;
    logic        rst_n  = 1'b0;
    logic        ir     = 1'b1;
    logic [31:0] frame;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        valid;
    logic        repeat_pulse;
    logic        err;
    logic [2:0]  err_code;
    logic        busy;

    ir_nec_rx #(
        .IR_ACTIVE_LOW(1), .SYNC_STAGES(S), .TOL_US(TOL),
        .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .REP_SPACE_US(RS),
        .BIT_MARK_US(BM), .BIT0_SPACE_US(B0), .BIT1_SPACE_US(B1),
        .TIMEOUT_US(TO), .REPEAT_WIN_US(RW), .CHECK_ADDR(1), .CHECK_CMD(1)
    ) dut (
        .clk_1m(clk_1m), .rst_n(rst_n), .ir(ir),
        .frame(frame), .addr(addr), .cmd(cmd),
        .valid(valid), .repeat_pulse(repeat_pulse),
        .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk_1m = ~clk_1m;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0, n_rep = 0, n_err = 0;
    int v0, r0, e0;
    int q[$];
    logic [31:0] exp_frame = 32'd0;
    logic [2:0]  exp_code  = 3'd0;

    always @(negedge clk_1m) begin
        if (valid)        n_valid++;
        if (repeat_pulse) n_rep++;
        if (err)          n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        v0 = n_valid; r0 = n_rep; e0 = n_err;
    endtask

    task automatic chk_counts(input string tag, input int dv, input int dr, input int de);
        chk({tag, "_valid_cnt"}, n_valid - v0, dv);
        chk({tag, "_rep_cnt"},   n_rep - r0,   dr);
        chk({tag, "_err_cnt"},   n_err - e0,   de);
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_frame"},    frame,    exp_frame);
        chk({tag, "_addr"},     addr,     exp_frame[15:0]);
        chk({tag, "_cmd"},      cmd,      exp_frame[23:16]);
        chk({tag, "_err_code"}, err_code, exp_code);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_1m);
        #1;
    endtask

    // Even entries of q are marks (ir=0), odd entries spaces; the line returns to idle afterwards
    task automatic play();
        foreach (q[i]) begin
            ir = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (q[i]) @(posedge clk_1m);
            #1;
        end
        ir = 1'b1;
        q.delete();
    endtask

    function automatic int dur(input int n, input bit j);
        return j ? n + int'($urandom_range(0, 2 * TOL)) - TOL : n;
    endfunction

    task automatic push_frame(input logic [31:0] data, input bit j);
        q.push_back(dur(LM, j));
        q.push_back(dur(LS, j));
        for (int i = 0; i < 32; i++) begin
            q.push_back(dur(BM, j));
            q.push_back(dur(data[i] ? B1 : B0, j));
        end
        q.push_back(dur(BM, j));
    endtask

    task automatic push_repeat();
        q.push_back(LM); q.push_back(RS); q.push_back(BM);
    endtask

    function automatic bit model_ok(input logic [31:0] d);
        return (d[15:8] == ~d[7:0]) && (d[31:24] == ~d[23:16]);
    endfunction

    task automatic run_frame(input string tag, input logic [31:0] d, input bit j);
        snap();
        push_frame(d, j);
        play();
        idle(40);
        if (model_ok(d)) begin
            exp_frame = d;
            chk_counts(tag, 1, 0, 0);
        end else begin
            exp_code = 3'd4;
            chk_counts(tag, 0, 0, 1);
        end
        chk_outs(tag);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  a8, c8;
        int          lat;

        idle(3);
        chk_outs("reset");
        chk("reset_busy", busy, 1'b0);
        chk("reset_pulses", {valid, repeat_pulse, err}, 3'b000);
        rst_n = 1'b1;
        idle(20);

        run_frame("s1", 32'hF708FB04, 1'b0);

        idle(2000);
        snap(); push_repeat(); play(); idle(40);
        chk_counts("s2_rep", 0, 1, 0);
        chk_outs("s2_rep");
        idle(6000);
        snap(); push_repeat(); play(); idle(40);
        exp_code = 3'd6;
        chk_counts("s2_orphan", 0, 0, 1);
        chk_outs("s2_orphan");

        run_frame("s3", 32'hF608FB04, 1'b0);

        snap(); q.push_back(350); play(); idle(40);
        exp_code = 3'd1;
        chk_counts("s4_lead", 0, 0, 1);
        chk_outs("s4_lead");

        d = 32'hE31C7F80;
        snap(); push_frame(d, 1'b0); q[3 + 2 * 7] = B1 + TOL; play(); idle(40);
        exp_frame = d;
        chk_counts("s4_tol_edge", 1, 0, 0);
        chk_outs("s4_tol_edge");

        snap(); push_frame(32'hF708FB04, 1'b0); q[3 + 2 * 7] = B1 + TOL + 1;
        while (q.size() > 2 + 2 * 8 + 1) void'(q.pop_back());
        play(); idle(40);
        exp_code = 3'd3;
        chk_counts("s4_tol_over", 0, 0, 1);
        chk_outs("s4_tol_over");

        snap(); push_frame(32'hF708FB04, 1'b0);
        while (q.size() > 2 + 2 * 20 + 1) void'(q.pop_back());
        play(); idle(590);
        chk_counts("s5_early", 0, 0, 0);
        chk("s5_busy_early", busy, 1'b1);
        idle(160);
        exp_code = 3'd5;
        chk_counts("s5_timeout", 0, 0, 1);
        chk("s5_busy_late", busy, 1'b0);
        chk_outs("s5_timeout");
        run_frame("s5_next", 32'h40BF12ED, 1'b0);

        snap(); push_frame(32'hF708FB04, 1'b0);
        while (q.size() > 2 + 2 * 10) void'(q.pop_back());
        play();
        chk("s6_busy_mid", busy, 1'b1);
        rst_n = 1'b0;
        idle(3);
        exp_frame = 32'd0; exp_code = 3'd0;
        chk_outs("s6_reset");
        chk("s6_reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(100);
        chk_counts("s6_broken", 0, 0, 0);

        d = 32'h9D62AA55;
        snap(); push_frame(d, 1'b0); void'(q.pop_back()); play();
        ir = 1'b0;
        idle(BM);
        ir = 1'b1;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            if (valid && lat == 99) lat = k;
        end
        chk("s6_latency", lat, S + 2);
        exp_frame = d;
        idle(20);
        chk_counts("s6_next", 1, 0, 0);
        chk_outs("s6_next");

        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom);
            c8 = 8'($urandom);
            if ($urandom_range(0, 2) != 0) d = {~c8, c8, ~a8, a8};
            else                           d = $urandom;
            run_frame($sformatf("rand%0d", i), d, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
